// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter that
// multiplexes the CPU fetch and data ports onto one memory interface.
package mem_port_arbiter_pkg;

  localparam int DATA_W         = 32;
  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 3;
  localparam int LAT_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_sel_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio.sv
// Fetch/data priority select with a starvation counter that forces a fetch
// after STARVE_MAX consecutive conflicts won by the data port.
module arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output gnt_sel_e         gnt_sel,
  output logic [CNT_W-1:0] starve_cnt_nxt
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Grant select and next starvation count from the request pair.
  always_comb begin
    gnt_sel        = GNT_NONE;
    starve_cnt_nxt = starve_cnt;
    case ({if_req, d_req})
      2'b11: begin
        if (starve_cnt < STARVE_LIM) begin
          gnt_sel        = GNT_D;
          starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end else begin
          gnt_sel        = GNT_IF;
          starve_cnt_nxt = '0;
        end
      end
      2'b10: begin
        gnt_sel        = GNT_IF;
        starve_cnt_nxt = '0;
      end
      2'b01: begin
        gnt_sel        = GNT_D;
        starve_cnt_nxt = starve_cnt;
      end
      default: begin
        gnt_sel        = GNT_NONE;
        starve_cnt_nxt = starve_cnt;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one fixed-latency memory port;
// one access in flight at a time, busy doubles as the CPU stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               CNT_W    = cnt_width(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d, starve_nxt;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  gnt_sel_e            gnt_sel;
  logic                done;

  arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_arb_prio (
    .if_req         (if_req),
    .d_req          (d_req),
    .starve_cnt     (starve_q),
    .gnt_sel        (gnt_sel),
    .starve_cnt_nxt (starve_nxt)
  );

  // A zero counter in a busy state would otherwise hang the port.
  assign done = (lat_q <= LAT_W'(1));

  // Next-state, latency, starvation and captured-request logic.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        starve_d = starve_nxt;
        case (gnt_sel)
          GNT_IF: begin
            state_d = ST_BUSY_IF;
            lat_d   = LAT_INIT;
            addr_d  = if_addr;
            wdata_d = '0;
          end
          GNT_D: begin
            state_d = ST_BUSY_D;
            lat_d   = LAT_INIT;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (done) begin
          state_d = ST_IDLE;
          lat_d   = '0;
        end else begin
          lat_d   = lat_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // Memory-side and port-side outputs; everything is forced low in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          case (gnt_sel)
            GNT_IF: begin
              if_gnt   = 1'b1;
              mem_en   = 1'b1;
              mem_addr = if_addr;
            end
            GNT_D: begin
              d_gnt     = 1'b1;
              mem_en    = 1'b1;
              mem_we    = d_we;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
            end
            default: begin
              mem_en = 1'b0;
            end
          endcase
        end
        ST_BUSY_IF: begin
          busy      = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          if_rvalid = done;
          if_rdata  = done ? mem_rdata : '0;
        end
        ST_BUSY_D: begin
          busy      = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          d_rvalid  = done;
          d_rdata   = done ? mem_rdata : '0;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end else begin
      busy = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances at MEM_LAT 1..3 share stimulus,
// each with its own fixed-latency memory model; a queue holds expected returns.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NI = 3;

  typedef struct {
    bit          is_d;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt_w    [NI];
  logic        if_rvalid_w [NI];
  logic [31:0] if_rdata_w  [NI];
  logic        d_gnt_w     [NI];
  logic        d_rvalid_w  [NI];
  logic [31:0] d_rdata_w   [NI];
  logic        mem_en_w    [NI];
  logic        mem_we_w    [NI];
  logic [31:0] mem_addr_w  [NI];
  logic [31:0] mem_wdata_w [NI];
  logic [31:0] mem_rdata_w [NI];
  logic        busy_w      [NI];

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cur    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0000_0013;
      32'h0000_0200: return 32'h1234_5678;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [2:0]  cnt;
    logic [31:0] addr_c;

    mem_port_arbiter #(.MEM_LAT(g + 1), .STARVE_MAX(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt_w[g]),
      .if_rvalid (if_rvalid_w[g]),
      .if_rdata  (if_rdata_w[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_w[g]),
      .d_rvalid  (d_rvalid_w[g]),
      .d_rdata   (d_rdata_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g]),
      .busy      (busy_w[g])
    );

    // Memory returns data only on the cycle exactly MEM_LAT after mem_en.
    always @(posedge clk) begin
      if (rst) cnt <= 3'd0;
      else if (mem_en_w[g]) begin
        cnt    <= 3'(g + 1);
        addr_c <= mem_addr_w[g];
      end else if (cnt != 3'd0) cnt <= cnt - 3'd1;
    end
    assign mem_rdata_w[g] = (cnt == 3'd1) ? mem_word(addr_c) : 32'hBAD0_BAD0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    cyc(); cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h44; d_addr = 32'h88; d_wdata = 32'h5555_AAAA;
    cyc(); cyc(); smp();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({if_gnt_w[i], d_gnt_w[i], if_rvalid_w[i], d_rvalid_w[i], mem_en_w[i], mem_we_w[i], busy_w[i]} !== 7'd0 ||
          (if_rdata_w[i] | d_rdata_w[i] | mem_addr_w[i] | mem_wdata_w[i]) !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: gnt=%b%b mem_en=%b busy=%b mem_addr=%h, required all 0",
                 i, if_gnt_w[i], d_gnt_w[i], mem_en_w[i], busy_w[i], mem_addr_w[i]);
      end
    end
    cyc();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    smp();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({if_gnt_w[i], d_gnt_w[i], mem_en_w[i], busy_w[i]} !== 4'd0) begin
        errors++;
        $display("FAIL idle_outputs[%0d]: gnt=%b%b mem_en=%b busy=%b, required 0", i,
                 if_gnt_w[i], d_gnt_w[i], mem_en_w[i], busy_w[i]);
      end
    end
    cyc();
  endtask

  task automatic test_fetch();
    exp_t e;
    cur = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    smp();
    checks++;
    if ({if_gnt_w[cur], d_gnt_w[cur], mem_en_w[cur], mem_we_w[cur], busy_w[cur]} !== 5'b10100 ||
        mem_addr_w[cur] !== 32'h10) begin
      errors++;
      $display("FAIL fetch_grant: gnt/dgnt/en/we/busy=%b%b%b%b%b addr=%h, required 10100 addr=00000010",
               if_gnt_w[cur], d_gnt_w[cur], mem_en_w[cur], mem_we_w[cur], busy_w[cur], mem_addr_w[cur]);
    end
    exp_q.push_back('{is_d: 1'b0, chk: 1'b1, data: mem_word(if_addr)});
    cyc();
    if_req = 1'b0;
    smp();
    checks++;
    if ({busy_w[cur], mem_en_w[cur], if_gnt_w[cur], d_rdata_w[cur]} !== {3'b100, 32'd0}) begin
      errors++;
      $display("FAIL fetch_busy: busy=%b mem_en=%b if_gnt=%b d_rdata=%h, required 1 0 0 0",
               busy_w[cur], mem_en_w[cur], if_gnt_w[cur], d_rdata_w[cur]);
    end
    checks++;
    if (if_rvalid_w[cur] !== 1'b1 || d_rvalid_w[cur] !== 1'b0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL fetch_rvalid: if_rvalid=%b d_rvalid=%b, required 1 0", if_rvalid_w[cur], d_rvalid_w[cur]);
    end else begin
      e = exp_q.pop_front();
      if (if_rdata_w[cur] !== e.data) begin
        errors++;
        $display("FAIL fetch_rdata: got %h, required %h", if_rdata_w[cur], e.data);
      end
    end
    cyc(); smp();
    checks++;
    if ({busy_w[cur], if_rvalid_w[cur], if_rdata_w[cur]} !== 34'd0) begin
      errors++;
      $display("FAIL fetch_idle: busy=%b if_rvalid=%b if_rdata=%h, required 0", busy_w[cur], if_rvalid_w[cur], if_rdata_w[cur]);
    end
    cyc();
  endtask

  task automatic test_starvation();
    exp_t        e;
    logic [31:0] got;
    bit          exp_d [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int          n;
    bit          drop;
    cur = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    n = 0; drop = 1'b0;
    for (int c = 0; c < 60 && (n < 8 || exp_q.size() > 0); c++) begin
      smp();
      checks++;
      if ((if_gnt_w[cur] && d_gnt_w[cur]) || (if_rvalid_w[cur] && d_rvalid_w[cur])) begin
        errors++;
        $display("FAIL starve_onehot: gnt=%b%b rvalid=%b%b, required at most one", if_gnt_w[cur], d_gnt_w[cur],
                 if_rvalid_w[cur], d_rvalid_w[cur]);
      end
      if (if_rvalid_w[cur] || d_rvalid_w[cur]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL starve_sb: rvalid with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          got = e.is_d ? d_rdata_w[cur] : if_rdata_w[cur];
          if (d_rvalid_w[cur] !== e.is_d || got !== e.data) begin
            errors++;
            $display("FAIL starve_data: port_d=%b data=%h, required port_d=%b data=%h", d_rvalid_w[cur], got, e.is_d, e.data);
          end
        end
      end
      if ((if_gnt_w[cur] || d_gnt_w[cur]) && n < 8) begin
        checks++;
        if (d_gnt_w[cur] !== exp_d[n]) begin
          errors++;
          $display("FAIL starve_order[%0d]: d_gnt=%b, required %b", n, d_gnt_w[cur], exp_d[n]);
        end
        exp_q.push_back('{is_d: d_gnt_w[cur], chk: 1'b1, data: d_gnt_w[cur] ? mem_word(d_addr) : mem_word(if_addr)});
        n++;
        if (n == 8) drop = 1'b1;
      end
      cyc();
      if (drop) begin if_req = 1'b0; d_req = 1'b0; end
    end
    checks++;
    if (n != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_timeout: grants=%0d pending=%0d, required 8 and 0", n, exp_q.size());
    end
  endtask

  task automatic test_store();
    exp_t e;
    int   rv_c, gnt_c;
    bit   fin;
    cur = 2;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    smp();
    checks++;
    if ({if_gnt_w[cur], d_gnt_w[cur], mem_en_w[cur], mem_we_w[cur], busy_w[cur]} !== 5'b01110 ||
        mem_addr_w[cur] !== 32'h100 || mem_wdata_w[cur] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_grant: gnt/dgnt/en/we/busy=%b%b%b%b%b addr=%h wdata=%h, required 01110 00000100 deadbeef",
               if_gnt_w[cur], d_gnt_w[cur], mem_en_w[cur], mem_we_w[cur], busy_w[cur], mem_addr_w[cur], mem_wdata_w[cur]);
    end
    exp_q.push_back('{is_d: 1'b1, chk: 1'b0, data: 32'd0});
    cyc();
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    if_req = 1'b1; if_addr = 32'h10;
    rv_c = -1; gnt_c = -1;
    for (int c = 1; c <= 8 && gnt_c < 0; c++) begin
      smp();
      if (d_rvalid_w[cur] || if_rvalid_w[cur]) begin
        rv_c = c;
        checks++;
        if (exp_q.size() == 0 || d_rvalid_w[cur] !== 1'b1) begin
          errors++;
          $display("FAIL store_complete: d_rvalid=%b if_rvalid=%b, required d_rvalid only", d_rvalid_w[cur], if_rvalid_w[cur]);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_d) begin errors++; $display("FAIL store_sb: popped fetch entry, required data entry"); end
        end
      end
      if (if_gnt_w[cur]) begin
        gnt_c = c;
        exp_q.push_back('{is_d: 1'b0, chk: 1'b1, data: mem_word(if_addr)});
      end
      if (c < 3) begin
        checks++;
        if ({mem_en_w[cur], mem_we_w[cur], busy_w[cur]} !== 3'b001 || mem_addr_w[cur] !== 32'h100 ||
            mem_wdata_w[cur] !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL store_hold c%0d: en/we/busy=%b%b%b addr=%h wdata=%h, required 001 00000100 deadbeef", c,
                   mem_en_w[cur], mem_we_w[cur], busy_w[cur], mem_addr_w[cur], mem_wdata_w[cur]);
        end
      end
      cyc();
    end
    if_req = 1'b0;
    checks++;
    if (rv_c != 3) begin errors++; $display("FAIL store_rvalid_cycle: got %0d, required 3", rv_c); end
    checks++;
    if (gnt_c != 4) begin errors++; $display("FAIL store_next_grant: got cycle %0d, required 4", gnt_c); end
    fin = 1'b0;
    for (int c = 0; c < 6 && !fin; c++) begin
      smp();
      if (if_rvalid_w[cur]) begin
        fin = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL store_fetch_sb: rvalid with empty scoreboard, required an entry");
        end else begin
          e = exp_q.pop_front();
          if (if_rdata_w[cur] !== e.data) begin
            errors++; $display("FAIL store_fetch_rdata: got %h, required %h", if_rdata_w[cur], e.data);
          end
        end
      end
      cyc();
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL store_fetch_timeout: no if_rvalid, required one"); end
  endtask

  task automatic test_reset_busy();
    exp_t e;
    int   rv_c;
    cur = 1;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    smp();
    checks++;
    if (if_gnt_w[cur] !== 1'b1) begin errors++; $display("FAIL rstbusy_grant: if_gnt=%b, required 1", if_gnt_w[cur]); end
    cyc();
    if_req = 1'b0; rst = 1'b1;
    smp();
    checks++;
    if ({if_gnt_w[cur], d_gnt_w[cur], if_rvalid_w[cur], d_rvalid_w[cur], mem_en_w[cur], mem_we_w[cur], busy_w[cur]} !== 7'd0 ||
        (if_rdata_w[cur] | d_rdata_w[cur] | mem_addr_w[cur] | mem_wdata_w[cur]) !== 32'd0) begin
      errors++;
      $display("FAIL rstbusy_outputs: busy=%b mem_addr=%h if_rvalid=%b, required all 0", busy_w[cur], mem_addr_w[cur], if_rvalid_w[cur]);
    end
    cyc();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h20;
    smp();
    checks++;
    if ({if_gnt_w[cur], if_rvalid_w[cur], d_rvalid_w[cur], mem_en_w[cur], busy_w[cur]} !== 5'b10010 ||
        mem_addr_w[cur] !== 32'h20) begin
      errors++;
      $display("FAIL rstbusy_regrant: gnt/ifrv/drv/en/busy=%b%b%b%b%b addr=%h, required 10010 00000020",
               if_gnt_w[cur], if_rvalid_w[cur], d_rvalid_w[cur], mem_en_w[cur], busy_w[cur], mem_addr_w[cur]);
    end
    exp_q.push_back('{is_d: 1'b0, chk: 1'b1, data: mem_word(if_addr)});
    cyc();
    if_req = 1'b0;
    rv_c = -1;
    for (int c = 1; c <= 4 && rv_c < 0; c++) begin
      smp();
      if (if_rvalid_w[cur] || d_rvalid_w[cur]) begin
        rv_c = c;
        checks++;
        if (exp_q.size() == 0 || if_rvalid_w[cur] !== 1'b1) begin
          errors++; $display("FAIL rstbusy_sb: if_rvalid=%b d_rvalid=%b, required fetch return", if_rvalid_w[cur], d_rvalid_w[cur]);
        end else begin
          e = exp_q.pop_front();
          if (if_rdata_w[cur] !== e.data) begin
            errors++; $display("FAIL rstbusy_rdata: got %h, required %h", if_rdata_w[cur], e.data);
          end
        end
      end
      cyc();
    end
    checks++;
    if (rv_c != 2) begin errors++; $display("FAIL rstbusy_latency: rvalid at cycle %0d, required 2", rv_c); end
  endtask

  task automatic test_load_pending();
    exp_t e;
    cur = 0;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h30;
    smp();
    checks++;
    if ({if_gnt_w[cur], d_gnt_w[cur], mem_we_w[cur]} !== 3'b010) begin
      errors++; $display("FAIL load_grant: if_gnt/d_gnt/we=%b%b%b, required 010", if_gnt_w[cur], d_gnt_w[cur], mem_we_w[cur]);
    end
    exp_q.push_back('{is_d: 1'b1, chk: 1'b1, data: mem_word(d_addr)});
    cyc();
    d_req = 1'b0;
    smp();
    checks++;
    if ({if_gnt_w[cur], d_gnt_w[cur], if_rvalid_w[cur], d_rvalid_w[cur]} !== 4'b0001 || if_rdata_w[cur] !== 32'd0) begin
      errors++;
      $display("FAIL load_complete: gnt=%b%b rvalid=%b%b if_rdata=%h, required 00 01 00000000",
               if_gnt_w[cur], d_gnt_w[cur], if_rvalid_w[cur], d_rvalid_w[cur], if_rdata_w[cur]);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL load_sb: empty scoreboard, required an entry");
    end else begin
      e = exp_q.pop_front();
      if (d_rdata_w[cur] !== e.data) begin errors++; $display("FAIL load_rdata: got %h, required %h", d_rdata_w[cur], e.data); end
    end
    cyc(); smp();
    checks++;
    if (if_gnt_w[cur] !== 1'b1 || mem_addr_w[cur] !== 32'h30) begin
      errors++; $display("FAIL load_next_fetch: if_gnt=%b addr=%h, required 1 00000030", if_gnt_w[cur], mem_addr_w[cur]);
    end
    exp_q.push_back('{is_d: 1'b0, chk: 1'b1, data: mem_word(if_addr)});
    cyc();
    if_req = 1'b0;
    smp();
    checks++;
    if (if_rvalid_w[cur] !== 1'b1 || exp_q.size() == 0) begin
      errors++; $display("FAIL load_fetch_rvalid: if_rvalid=%b, required 1", if_rvalid_w[cur]);
    end else begin
      e = exp_q.pop_front();
      if (if_rdata_w[cur] !== e.data) begin errors++; $display("FAIL load_fetch_rdata: got %h, required %h", if_rdata_w[cur], e.data); end
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_store();
    test_reset_busy();
    test_load_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles from the mem_en issue cycle to mem_rdata valid; legal range 1..4.
REQ-002 Parameter STARVE_MAX, default 3: maximum number of consecutive conflicts the data port may win before fetch is forced.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch read request; held until if_gnt.
REQ-006 if_addr  in  32  fetch address (PC).
REQ-007 if_gnt  out  1  fetch accepted this cycle.
REQ-008 if_rvalid  out  1  if_rdata valid; one-cycle pulse.
REQ-009 if_rdata  out  32  instruction word.
REQ-010 d_req  in  1  data request; held until d_gnt.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  data accepted this cycle.
REQ-015 d_rvalid  out  1  load data valid or store complete; one-cycle pulse.
REQ-016 d_rdata  out  32  load data.
REQ-017 mem_en  out  1  memory access strobe.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  32  memory address.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data; valid MEM_LAT cycles after mem_en.
REQ-022 busy  out  1  an access is outstanding; the CPU uses it as its stall.

Function
REQ-023 FSM states: IDLE, BUSY_IF, BUSY_D.
REQ-024 In IDLE, a grant is combinational from the request lines: mem_en=1, the granted port's gnt=1, and mem_addr/mem_we/mem_wdata driven from that port.
- Fetch grant: mem_we=0.
- Next state: BUSY_IF or BUSY_D.
REQ-025 Conflict (if_req and d_req both high in IDLE):
- Data wins while starve_cnt < STARVE_MAX, and starve_cnt increments.
- Fetch wins when starve_cnt == STARVE_MAX, and starve_cnt clears to 0.
REQ-026 Any fetch grant clears starve_cnt; a non-conflict data grant leaves it unchanged.
REQ-027 Latency counter loads MEM_LAT on grant and decrements each BUSY cycle; the cycle it reads 1 is the completion cycle.
REQ-028 Completion cycle behaviour:
- The owning port's rvalid=1 and its rdata = mem_rdata (combinational pass-through).
- The other port's rdata holds 0.
- The FSM returns to IDLE.
REQ-029 A store completion asserts d_rvalid; d_rdata is don't-care.
REQ-030 No grant is issued while in BUSY_*; the earliest next grant is the cycle after completion, so each access occupies MEM_LAT+1 cycles.
REQ-031 busy=1 in BUSY_IF and BUSY_D; busy=0 in IDLE, including the grant cycle.
REQ-032 mem_en=0 and mem_we=0 in BUSY_*; mem_addr and mem_wdata hold the granted values, registered at grant.
REQ-033 Request lines are ignored outside IDLE; a request dropped before grant is never serviced.
REQ-034 At most one gnt and at most one rvalid are high in any cycle.

Reset
REQ-035 While rst=1: state=IDLE, starve_cnt=0, latency counter=0, and all outputs are 0.
REQ-036 Reset during BUSY_* abandons the access with no rvalid; the first grant is possible in the first cycle after rst falls.

Structure
REQ-037 A shared package holds the state encoding, the MEM_LAT/STARVE_MAX defaults and the width constant 32.
REQ-038 The conflict priority and starvation logic is one sub-module, arb_prio (inputs: if_req, d_req, starve_cnt; outputs: grant select, counter update).

Verification
REQ-039 MEM_LAT=1, if_req only, if_addr=0x0000_0010, mem_rdata=0x0000_0013 -> if_gnt and mem_en in cycle 0; if_rvalid with if_rdata=0x0000_0013 in cycle 1; busy=1 in cycle 1.
REQ-040 STARVE_MAX=3, if_req and d_req held high continuously -> grant order D,D,D,IF,D,D,D,IF.
REQ-041 MEM_LAT=3, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> mem_we=1 with those values in cycle 0; d_rvalid in cycle 3; next grant no earlier than cycle 4.
REQ-042 rst pulsed in the cycle after a grant (MEM_LAT=2) -> no rvalid; all outputs 0; a new if_req after reset is granted in the first cycle after rst falls.
REQ-043 Data load returning 0x1234_5678 while if_req is pending -> d_rvalid only, if_rdata=0, if_gnt in the cycle after completion.
